// File: rtl/llc_pipe_skid_reg.sv
// Valid-ready pipeline stage with a registered ready path and a 2-entry skid buffer.
// All outputs decode from registers, so no input reaches an output combinationally.
module llc_pipe_skid_reg #(
  parameter int  DATA_WIDTH  = 32,
  parameter type dtype       = logic [DATA_WIDTH-1:0],
  parameter int  STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   valid_in,
  input  dtype                   data_in,
  output logic                   ready_out,
  output logic                   valid_out,
  output dtype                   data_out,
  input  logic                   ready_in,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // state | meaning
  // EMPTY | no beat buffered, upstream may send
  // ONE   | main entry holds the head beat, skid free
  // FULL  | main and skid both hold beats, upstream held off
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q;
  dtype                   main_q;
  dtype                   skid_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic accept;
  logic send;

  assign valid_out = (state_q != EMPTY);
  assign ready_out = (state_q != FULL);
  assign data_out  = main_q;
  assign stall_cnt = stall_q;

  assign accept = valid_in && ready_out;
  assign send   = valid_out && ready_in;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      if (valid_out && !ready_in && (stall_q != '1))
        stall_q <= stall_q + STALL_CNT_W'(1);

      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= ONE;
            main_q  <= data_in;
          end
        end
        ONE: begin
          if (accept && send) begin
            main_q <= data_in;
          end else if (accept) begin
            // Head beat stalled: the in-flight beat parks in skid behind it.
            state_q <= FULL;
            skid_q  <= data_in;
          end else if (send) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (send) begin
            state_q <= ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_pipe_skid_reg.sv
// Bench for llc_pipe_skid_reg: hand vector table, saturation and async-reset
// sequences, then a long random run against a queue scoreboard.
module tb_llc_pipe_skid_reg;

  localparam int DW = 16;
  localparam int SW = 4;
  localparam int STALL_MAX = 15;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  llc_pipe_skid_reg #(.DATA_WIDTH(DW), .STALL_CNT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          f;
    logic          vin;
    logic [DW-1:0] din;
    logic          rin;
    logic          ev;
    logic          er;
    logic [1:0]    eo;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb_q[$];
  int            exp_stall;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  int            tests;
  int            failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_stall  = 0;
    prev_stall = 1'b0;
  endtask

  // One cycle: check outputs against the scoreboard, drive inputs, advance the model.
  task automatic step(input logic f, input logic vin, input logic [DW-1:0] din, input logic rin);
    int   sz;
    logic acc;
    logic snd;
    @(negedge clk);
    sz = sb_q.size();
    chk("valid_out", 32'(valid_out), 32'(sz != 0));
    chk("ready_out", 32'(ready_out), 32'(sz < 2));
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    if (sz != 0) chk("data_out", 32'(data_out), 32'(sb_q[0]));
    if (prev_stall) begin
      chk("hold_valid", 32'(valid_out), 32'd1);
      chk("hold_data", 32'(data_out), 32'(prev_data));
    end
    flush    = f;
    valid_in = vin;
    data_in  = din;
    ready_in = rin;
    if (f) begin
      sb_q.delete();
      exp_stall  = 0;
      prev_stall = 1'b0;
    end else begin
      if (sz != 0 && !rin && exp_stall != STALL_MAX) exp_stall++;
      snd = (sz != 0) && rin;
      acc = vin && (sz < 2);
      prev_stall = (sz != 0) && !rin;
      if (sz != 0) prev_data = sb_q[0];
      if (snd) void'(sb_q.pop_front());
      if (acc) sb_q.push_back(din);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    prev_data = '0;
    model_reset();
    rst = 1'b0;
    flush = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    ready_in = 1'b0;

    // Streaming 1..8
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 1'b1, DW'(i + 1), 1'b1, (i != 0), 1'b1, (i != 0) ? 2'd1 : 2'd0, DW'(i), 4'd0});
    tbl.push_back('{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h8, 4'd0});
    tbl.push_back('{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0, 4'd0});
    // Stall with A, B; C offered while full and must never appear
    tbl.push_back('{1'b0, 1'b1, 16'h00A, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 16'h00B, 1'b0, 1'b1, 1'b1, 2'd1, 16'hA, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 16'h00C, 1'b0, 1'b1, 1'b0, 2'd2, 16'hA, 4'd1});
    tbl.push_back('{1'b0, 1'b0, 16'h000, 1'b0, 1'b1, 1'b0, 2'd2, 16'hA, 4'd2});
    tbl.push_back('{1'b0, 1'b0, 16'h000, 1'b1, 1'b1, 1'b0, 2'd2, 16'hA, 4'd3});
    tbl.push_back('{1'b0, 1'b0, 16'h000, 1'b1, 1'b1, 1'b1, 2'd1, 16'hB, 4'd3});
    tbl.push_back('{1'b0, 1'b0, 16'h000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0, 4'd3});
    // Fill to FULL, then flush with a concurrent accept/send offered
    tbl.push_back('{1'b0, 1'b1, 16'h011, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 4'd3});
    tbl.push_back('{1'b0, 1'b1, 16'h012, 1'b0, 1'b1, 1'b1, 2'd1, 16'h11, 4'd3});
    tbl.push_back('{1'b1, 1'b1, 16'h013, 1'b1, 1'b1, 1'b0, 2'd2, 16'h11, 4'd4});
    tbl.push_back('{1'b0, 1'b0, 16'h000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 16'h021, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 4'd0});

    #12 rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].vin, tbl[i].din, tbl[i].rin);
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(ready_out), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].es));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].ed));
    end

    // Saturation: one beat held with ready_in low for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      chk("sat_cnt", 32'(stall_cnt), (i < 15) ? 32'(i) : 32'd15);
    end
    step(1'b0, 1'b1, 16'h031, 1'b0);
    chk("sat_final", 32'(stall_cnt), 32'd15);
    chk("sat_data", 32'(data_out), 32'h21);

    // Async reset between edges while FULL
    @(negedge clk);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'd1);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
           DW'($urandom), ($urandom_range(0, 9) < 6));
    end

    // Drain, bounded
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("drain_valid", 32'(valid_out), 32'd0);
    chk("drain_sb", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
